// File: rtl/ppu_mode_sched.sv
// PPU dot scheduler: LX/LY counters, mode sequencing (OAM/XFER/HBLANK/VBLANK),
// CPU access locks, LY==LYC compare and edge-triggered STAT/VBLANK requests.
module ppu_mode_sched #(
  parameter int DOTS_PER_LINE = 456,
  parameter int LINES         = 154,
  parameter int VISIBLE_LINES = 144,
  parameter int OAM_DOTS      = 80,
  parameter int MODE3_MAX     = 289
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_ena,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_sel,
  input  logic       pix_done,
  output logic [8:0] lx,
  output logic [7:0] ly,
  output logic [1:0] mode,
  output logic       lyc_eq,
  output logic       xfer_start,
  output logic       vram_lock,
  output logic       oam_lock,
  output logic       stat_irq,
  output logic       vblank_irq
);

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_XFER   = 2'd3
  } mode_e;

  localparam logic [8:0] LX_LAST   = 9'(DOTS_PER_LINE - 1);
  localparam logic [7:0] LY_LAST   = 8'(LINES - 1);
  localparam logic [7:0] LY_VBLANK = 8'(VISIBLE_LINES);
  localparam logic [8:0] LX_XFER   = 9'(OAM_DOTS);
  localparam logic [8:0] XFER_LAST = 9'(MODE3_MAX - 1);

  mode_e      mode_q, mode_d;
  logic [8:0] lx_q, lx_d;
  logic [7:0] ly_q, ly_d;
  logic [8:0] xfer_cnt_q, xfer_cnt_d;
  logic       lcd_on_q, lcd_on_d;
  logic       stat_prev_q, stat_prev_d;
  logic       stat_irq_q, stat_irq_d;
  logic       vblank_irq_q, vblank_irq_d;
  logic       xfer_start_q, xfer_start_d;
  logic       stat_line;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lx_q         <= '0;
      ly_q         <= '0;
      mode_q       <= MODE_HBLANK;
      xfer_cnt_q   <= '0;
      lcd_on_q     <= 1'b0;
      stat_prev_q  <= 1'b0;
      stat_irq_q   <= 1'b0;
      vblank_irq_q <= 1'b0;
      xfer_start_q <= 1'b0;
    end else begin
      lx_q         <= lx_d;
      ly_q         <= ly_d;
      mode_q       <= mode_d;
      xfer_cnt_q   <= xfer_cnt_d;
      lcd_on_q     <= lcd_on_d;
      stat_prev_q  <= stat_prev_d;
      stat_irq_q   <= stat_irq_d;
      vblank_irq_q <= vblank_irq_d;
      xfer_start_q <= xfer_start_d;
    end
  end

  // Counters and mode advance together; dropping lcd_ena wins over everything.
  always_comb begin
    lx_d         = lx_q;
    ly_d         = ly_q;
    mode_d       = mode_q;
    xfer_cnt_d   = xfer_cnt_q;
    lcd_on_d     = lcd_on_q;
    stat_prev_d  = stat_line;
    stat_irq_d   = stat_line & ~stat_prev_q;
    vblank_irq_d = 1'b0;
    xfer_start_d = 1'b0;

    if (!lcd_ena) begin
      lx_d        = '0;
      ly_d        = '0;
      mode_d      = MODE_HBLANK;
      xfer_cnt_d  = '0;
      lcd_on_d    = 1'b0;
      stat_prev_d = 1'b0;
      stat_irq_d  = 1'b0;
    end else if (!lcd_on_q) begin
      lcd_on_d = 1'b1;
      lx_d     = '0;
      ly_d     = '0;
      mode_d   = MODE_OAM;
    end else if (lx_q == LX_LAST) begin
      lx_d = '0;
      ly_d = (ly_q == LY_LAST) ? 8'd0 : ly_q + 8'd1;
      if (ly_d < LY_VBLANK) begin
        mode_d = MODE_OAM;
      end else if (ly_d == LY_VBLANK) begin
        mode_d       = MODE_VBLANK;
        vblank_irq_d = 1'b1;
      end
    end else begin
      lx_d = lx_q + 9'd1;
      case (mode_q)
        MODE_OAM: begin
          if (lx_d == LX_XFER) begin
            mode_d       = MODE_XFER;
            xfer_cnt_d   = '0;
            xfer_start_d = 1'b1;
          end
        end
        // Transfer ends on pipeline completion or after the fixed timeout.
        MODE_XFER: begin
          if (pix_done || (xfer_cnt_q == XFER_LAST)) begin
            mode_d = MODE_HBLANK;
          end else begin
            xfer_cnt_d = xfer_cnt_q + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lyc_eq    = (ly_q == lyc);
    vram_lock = (mode_q == MODE_XFER);
    oam_lock  = (mode_q == MODE_OAM) || (mode_q == MODE_XFER);
    stat_line = lcd_on_q & ((stat_sel[0] & (mode_q == MODE_HBLANK)) |
                            (stat_sel[1] & (mode_q == MODE_VBLANK)) |
                            (stat_sel[2] & (mode_q == MODE_OAM))    |
                            (stat_sel[3] & lyc_eq));
  end

  assign lx         = lx_q;
  assign ly         = ly_q;
  assign mode       = mode_q;
  assign xfer_start = xfer_start_q;
  assign stat_irq   = stat_irq_q;
  assign vblank_irq = vblank_irq_q;

endmodule

// File: tb/tb_ppu_mode_sched.sv
// Self-checking bench for ppu_mode_sched: directed checkpoint table, hand
// sequences for disable/reset, and a dot-index reference model checked every cycle.
module tb_ppu_mode_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_ena = 1'b0;
  logic [7:0] lyc = 8'd0;
  logic [3:0] stat_sel = 4'd0;
  logic       pix_done = 1'b0;
  logic [8:0] lx;
  logic [7:0] ly;
  logic [1:0] mode;
  logic       lyc_eq, xfer_start, vram_lock, oam_lock, stat_irq, vblank_irq;

  int assertCount = 0;
  int failCount   = 0;

  localparam int FRAME_DOTS = 456 * 154;

  always #5 clk = ~clk;

  ppu_mode_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lcd_ena    (lcd_ena),
    .lyc        (lyc),
    .stat_sel   (stat_sel),
    .pix_done   (pix_done),
    .lx         (lx),
    .ly         (ly),
    .mode       (mode),
    .lyc_eq     (lyc_eq),
    .xfer_start (xfer_start),
    .vram_lock  (vram_lock),
    .oam_lock   (oam_lock),
    .stat_irq   (stat_irq),
    .vblank_irq (vblank_irq)
  );

  // Reference model: position is just the dot count since enable; mode 3
  // ends at the lx recorded when pix_done was seen, else at the timeout (369).
  int mT      = 0;
  bit mOn     = 0;
  int mDoneLx = 369;
  bit mPrev   = 0;
  bit mStat   = 0;

  function automatic int mLx();
    return mT % 456;
  endfunction

  function automatic int mLy();
    return (mT / 456) % 154;
  endfunction

  function automatic int mMode();
    if (!mOn) return 0;
    if (mLy() >= 144) return 1;
    if (mLx() < 80) return 2;
    if (mLx() < mDoneLx) return 3;
    return 0;
  endfunction

  function automatic bit mLine();
    int m;
    m = mMode();
    return mOn && ((stat_sel[0] && m == 0) || (stat_sel[1] && m == 1) ||
                   (stat_sel[2] && m == 2) || (stat_sel[3] && mLy() == int'(lyc)));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit line;
    if (!rst_n) begin
      mT = 0; mOn = 0; mDoneLx = 369; mPrev = 0; mStat = 0;
    end else begin
      line = mLine();
      if (!lcd_ena) begin
        mT = 0; mOn = 0; mDoneLx = 369; mPrev = 0; mStat = 0;
      end else if (!mOn) begin
        mOn = 1; mT = 0; mDoneLx = 369;
        mStat = line && !mPrev; mPrev = line;
      end else begin
        if (mMode() == 3 && pix_done) mDoneLx = mLx() + 1;
        mStat = line && !mPrev; mPrev = line;
        mT++;
        if (mLx() == 0) mDoneLx = 369;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int expectedVec();
    int m;
    logic [24:0] e;
    m = mMode();
    e = {9'(mLx()), 8'(mLy()), 2'(m), (mLy() == int'(lyc)),
         (mOn && mLy() < 144 && mLx() == 80), (m == 3), (m >= 2), mStat,
         (mOn && mLy() == 144 && mLx() == 0)};
    return int'(e);
  endfunction

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (failCount < 100)
      checkOutput("model", int'({lx, ly, mode, lyc_eq, xfer_start, vram_lock, oam_lock,
                                 stat_irq, vblank_irq}), expectedVec());
  end

  task automatic applyStimulus(input bit ena, input bit pix, input logic [7:0] lycV,
                               input logic [3:0] selV);
    lcd_ena  = ena;
    pix_done = pix;
    lyc      = lycV;
    stat_sel = selV;
    @(posedge clk);
    #2;
  endtask

  task automatic runTo(input int target, input logic [7:0] lycV, input logic [3:0] selV);
    int budget;
    budget = 80000;
    while (mT != target && budget > 0) begin
      applyStimulus(1'b1, 1'b0, lycV, selV);
      budget--;
    end
    if (budget == 0) begin
      failCount++;
      assertCount++;
      $display("[TB] FAIL runTo: reached dot %0d, required %0d", mT, target);
    end
  endtask

  typedef struct {
    int frame; int tly; int tlx; bit pix;
    int eMode; bit eXs; bit eVb; bit eStat; bit eLyc; bit eVram; bit eOam;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int pulses;
    bit ena, pix;
    logic [7:0] lycR;
    logic [3:0] selR;

    // Directed checkpoints with lyc=5, stat_sel={lyc,hblank}.
    vecs.push_back('{0,   0,   0, 0, 2, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0,   0,  79, 0, 2, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0,   0,  80, 0, 3, 1, 0, 0, 0, 1, 1});
    vecs.push_back('{0,   0,  81, 0, 3, 0, 0, 0, 0, 1, 1});
    vecs.push_back('{0,   0, 368, 0, 3, 0, 0, 0, 0, 1, 1});
    vecs.push_back('{0,   0, 369, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0,   0, 370, 0, 0, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{0,   0, 455, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0,   1,   0, 0, 2, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0,   2, 251, 1, 3, 0, 0, 0, 0, 1, 1});
    vecs.push_back('{0,   2, 252, 1, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0,   2, 253, 0, 0, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{0,   2, 254, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0,   4, 369, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0,   4, 370, 0, 0, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{0,   4, 371, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0,   5,   0, 0, 2, 0, 0, 0, 1, 0, 1});
    vecs.push_back('{0,   5,   1, 0, 2, 0, 0, 0, 1, 0, 1});
    vecs.push_back('{0,   5, 370, 0, 0, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{0,   6,   0, 0, 2, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0,   6, 370, 0, 0, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 143, 455, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 144,   0, 0, 1, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 144,   1, 0, 1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 153, 455, 0, 1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1,   0,   0, 0, 2, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{1,   0,  80, 0, 3, 1, 0, 0, 0, 1, 1});
    vecs.push_back('{1,  10, 200, 0, 3, 0, 0, 0, 0, 1, 1});

    $display("[TB] reset state");
    #1;
    checkOutput("reset_lx", lx, 0);
    checkOutput("reset_ly", ly, 0);
    checkOutput("reset_mode", mode, 0);
    checkOutput("reset_locks", {vram_lock, oam_lock}, 0);
    checkOutput("reset_pulses", {xfer_start, stat_irq, vblank_irq}, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'd5, 4'b1001);

    $display("[TB] directed checkpoint table");
    foreach (vecs[i]) begin
      runTo(vecs[i].frame * FRAME_DOTS + vecs[i].tly * 456 + vecs[i].tlx, 8'd5, 4'b1001);
      checkOutput($sformatf("vec%0d_lx", i), lx, vecs[i].tlx);
      checkOutput($sformatf("vec%0d_ly", i), ly, vecs[i].tly);
      checkOutput($sformatf("vec%0d_mode", i), mode, vecs[i].eMode);
      checkOutput($sformatf("vec%0d_xfer_start", i), xfer_start, vecs[i].eXs);
      checkOutput($sformatf("vec%0d_vblank_irq", i), vblank_irq, vecs[i].eVb);
      checkOutput($sformatf("vec%0d_stat_irq", i), stat_irq, vecs[i].eStat);
      checkOutput($sformatf("vec%0d_lyc_eq", i), lyc_eq, vecs[i].eLyc);
      checkOutput($sformatf("vec%0d_vram_lock", i), vram_lock, vecs[i].eVram);
      checkOutput($sformatf("vec%0d_oam_lock", i), oam_lock, vecs[i].eOam);
      if (vecs[i].pix) applyStimulus(1'b1, 1'b1, 8'd5, 4'b1001);
    end

    $display("[TB] disable mid mode 3, then re-enable");
    applyStimulus(1'b0, 1'b0, 8'd5, 4'b1001);
    checkOutput("dis_pos", {lx, ly}, 0);
    checkOutput("dis_mode", mode, 0);
    checkOutput("dis_locks", {vram_lock, oam_lock}, 0);
    checkOutput("dis_pulses", {xfer_start, stat_irq, vblank_irq}, 0);
    applyStimulus(1'b1, 1'b0, 8'd5, 4'b1001);
    checkOutput("reen_mode", mode, 2);
    checkOutput("reen_lx", lx, 0);
    applyStimulus(1'b1, 1'b0, 8'd5, 4'b1001);
    checkOutput("reen_lx1", lx, 1);

    $display("[TB] async reset mid-frame with lyc match select");
    for (int i = 0; i < 700; i++) applyStimulus(1'b1, 1'b0, 8'd0, 4'b1000);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_pos", {lx, ly}, 0);
    checkOutput("arst_mode", mode, 0);
    checkOutput("arst_locks", {vram_lock, oam_lock}, 0);
    checkOutput("arst_pulses", {xfer_start, stat_irq, vblank_irq}, 0);
    applyStimulus(1'b0, 1'b0, 8'd0, 4'b1000);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'd0, 4'b1000);
    checkOutput("arst_en_mode", mode, 2);
    checkOutput("arst_en_stat", stat_irq, 0);
    applyStimulus(1'b1, 1'b0, 8'd0, 4'b1000);
    checkOutput("arst_stat_pulse", stat_irq, 1);
    pulses = 0;
    for (int i = 0; i < 500; i++) begin
      applyStimulus(1'b1, 1'b0, 8'd0, 4'b1000);
      if (stat_irq) pulses++;
    end
    checkOutput("arst_no_repeat", pulses, 0);

    $display("[TB] randomized stimulus");
    lycR = 8'd2;
    selR = 4'b1111;
    for (int i = 0; i < 8000; i++) begin
      ena = ($urandom_range(0, 999) != 0);
      pix = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) lycR = 8'($urandom_range(0, 20));
      if ($urandom_range(0, 127) == 0) selR = 4'($urandom_range(0, 15));
      applyStimulus(ena, pix, lycR, selR);
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
